mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_stage_ex_mem_reg.sv | 46 ++++
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM encoding, default widths,
// and the hard-wired zero register index.
package mem_stage_pkg;

  localparam int unsigned DW       = 32;
  localparam int unsigned RW       = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_ex_mem_reg.sv
// EX/MEM pipeline capture register: holds the accepted EX result while the
// memory access is outstanding.
module ex_mem_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] alu_out_d,
  input  logic [DW-1:0] wdata_d,
  input  logic [RW-1:0] rd_d,
  input  logic          mem_read_d,
  input  logic          mem_write_d,
  input  logic          reg_write_d,
  input  logic          mem_to_reg_d,
  output logic [DW-1:0] alu_out_q,
  output logic [DW-1:0] wdata_q,
  output logic [RW-1:0] rd_q,
  output logic          mem_read_q,
  output logic          mem_write_q,
  output logic          reg_write_q,
  output logic          mem_to_reg_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q    <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (load) begin
      alu_out_q    <= alu_out_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: accepts EX results, issues word-aligned data-memory
// requests with a held handshake, and produces one-cycle writeback pulses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DW = mem_stage_pkg::DW,
  parameter int unsigned RW = mem_stage_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_flush,
  input  logic [DW-1:0] ex_alu_out,
  input  logic [DW-1:0] ex_wdata,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_reg_write,
  input  logic          ex_mem_to_reg,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          wb_misalign
);

  state_t        state_q, state_d;
  logic          accept, is_mem, misaligned;
  logic [DW-1:0] cap_alu_out, cap_wdata;
  logic [RW-1:0] cap_rd;
  logic          cap_mem_read, cap_mem_write, cap_reg_write, cap_mem_to_reg;
  logic          wb_valid_d, wb_reg_write_d, wb_misalign_d;
  logic [RW-1:0] wb_rd_d;
  logic [DW-1:0] wb_data_d;

  assign ex_ready   = (state_q == IDLE);
  assign accept     = ex_valid & ex_ready & ~ex_flush;
  assign is_mem     = ex_mem_read | ex_mem_write;
  assign misaligned = (ex_alu_out[1:0] != 2'b00);

  ex_mem_reg #(.DW(DW), .RW(RW)) u_ex_mem_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .alu_out_d    (ex_alu_out),
    .wdata_d      (ex_wdata),
    .rd_d         (ex_rd),
    .mem_read_d   (ex_mem_read),
    .mem_write_d  (ex_mem_write),
    .reg_write_d  (ex_reg_write),
    .mem_to_reg_d (ex_mem_to_reg),
    .alu_out_q    (cap_alu_out),
    .wdata_q      (cap_wdata),
    .rd_q         (cap_rd),
    .mem_read_q   (cap_mem_read),
    .mem_write_q  (cap_mem_write),
    .reg_write_q  (cap_reg_write),
    .mem_to_reg_q (cap_mem_to_reg)
  );

  // Request fields come straight from the capture register, so they stay
  // stable for the whole ACCESS period; a read+write op is issued as a write.
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = cap_mem_write;
  assign dmem_addr  = cap_alu_out;
  assign dmem_wdata = cap_wdata;

  always_comb begin
    state_d        = state_q;
    wb_valid_d     = 1'b0;
    wb_misalign_d  = 1'b0;
    wb_reg_write_d = wb_reg_write;
    wb_rd_d        = wb_rd;
    wb_data_d      = wb_data;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem && !misaligned) begin
            state_d = ACCESS;
          end else begin
            wb_valid_d     = 1'b1;
            wb_misalign_d  = is_mem;
            wb_rd_d        = ex_rd;
            wb_data_d      = ex_alu_out;
            wb_reg_write_d = ex_reg_write & ~is_mem & (ex_rd != RW'(REG_ZERO));
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d        = IDLE;
          wb_valid_d     = 1'b1;
          wb_rd_d        = cap_rd;
          wb_reg_write_d = cap_reg_write & (cap_rd != RW'(REG_ZERO));
          wb_data_d      = (cap_mem_read & ~cap_mem_write & cap_mem_to_reg) ?
                           dmem_rdata : cap_alu_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_misalign  <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      state_q      <= state_d;
      wb_valid     <= wb_valid_d;
      wb_reg_write <= wb_reg_write_d;
      wb_misalign  <= wb_misalign_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writebacks, a
// negedge monitor pops and compares each wb_valid pulse.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_flush;
  logic [31:0] ex_alu_out, ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .ex_alu_out(ex_alu_out), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic rdm, input logic wrm, input logic rw, input logic m2r,
                          input logic flush);
    ex_valid = 1'b1; ex_flush = flush; ex_alu_out = alu; ex_wdata = wd; ex_rd = rd;
    ex_mem_read = rdm; ex_mem_write = wrm; ex_reg_write = rw; ex_mem_to_reg = m2r;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_flush = 1'b0; ex_alu_out = '0; ex_wdata = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic rw, input logic mis);
    exp_t e;
    e.rd = rd; e.data = data; e.rw = rw; e.mis = mis;
    q.push_back(e);
  endtask

  // Hold the request for n cycles, acking in the last; then expect release.
  task automatic serve(input int n, input logic [31:0] rdata, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic we);
    for (int i = 1; i <= n; i++) begin
      if (i == n) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      @(negedge clk);
      chk("req_high", 32'(dmem_req), 32'd1);
      chk("req_addr", dmem_addr, addr);
      chk("req_wdata", dmem_wdata, wdata);
      chk("req_we", 32'(dmem_we), 32'(we));
      chk("ready_low", 32'(ex_ready), 32'd0);
      step();
      dmem_ack = 1'b0;
    end
    @(negedge clk);
    chk("req_released", 32'(dmem_req), 32'd0);
    chk("ready_back", 32'(ex_ready), 32'd1);
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("wb_misalign", 32'(wb_misalign), 32'(e.mis));
      end
    end else if (rst_n && wb_misalign) begin
      chk("misalign_without_valid", 32'(wb_misalign), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    idle_ex();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_misalign", 32'(wb_misalign), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("ready_after_reset", 32'(ex_ready), 32'd1);
    step();

    // ALU op
    drive_op(32'h10, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(5'd3, 32'h10, 1'b1, 1'b0);
    step(); idle_ex();
    @(negedge clk);
    chk("alu_no_req", 32'(dmem_req), 32'd0);
    step();

    // Load, ack in third request cycle
    drive_op(32'h100, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    push(5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(); idle_ex();
    serve(3, 32'hDEAD_BEEF, 32'h100, 32'h0, 1'b0);

    // Store, ack in first request cycle
    drive_op(32'h204, 32'h55, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(5'd4, 32'h204, 1'b0, 1'b0);
    step(); idle_ex();
    serve(1, 32'h0, 32'h204, 32'h55, 1'b1);

    // Read and write both set: issued as a write
    drive_op(32'h208, 32'hA5A5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(5'd6, 32'h208, 1'b1, 1'b0);
    step(); idle_ex();
    serve(2, 32'h1234, 32'h208, 32'hA5A5, 1'b1);

    // Misaligned load
    drive_op(32'h102, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    push(5'd7, 32'h102, 1'b0, 1'b1);
    step(); idle_ex();
    @(negedge clk);
    chk("misalign_no_req", 32'(dmem_req), 32'd0);
    chk("misalign_ready", 32'(ex_ready), 32'd1);
    step();

    // Flushed op, then ALU op to x0
    drive_op(32'h40, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); idle_ex();
    @(negedge clk);
    chk("flush_no_wb", 32'(wb_valid), 32'd0);
    step();
    drive_op(32'h44, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(5'd0, 32'h44, 1'b0, 1'b0);
    step(); idle_ex();
    @(negedge clk);
    step();

    // Back-to-back ALU ops
    drive_op(32'h20, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(5'd1, 32'h20, 1'b1, 1'b0);
    step();
    drive_op(32'h24, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(5'd2, 32'h24, 1'b1, 1'b0);
    step(); idle_ex();
    repeat (2) step();

    // Reset during ACCESS, before any ack
    drive_op(32'h300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); idle_ex();
    @(negedge clk);
    chk("pre_reset_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(dmem_req), 32'd0);
    chk("async_addr_clear", dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(ex_ready), 32'd1);
    chk("no_wb_after_abort", 32'(wb_valid), 32'd0);
    chk("no_req_after_abort", 32'(dmem_req), 32'd0);
    repeat (3) step();

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
